gl_matrix_stack: RTL and testbench
==================================

Name: gl_matrix_stack

Overview:
- Matrix storage stage directly downstream of the command decoder.
- Holds the current modelview and projection matrices, each with its own push/pop stack.
- Executes the decoder's push, pop, load, load-identity and multiply-writeback requests.
- Presents both top-of-stack matrices to the matrix multiplier as flat 512-bit buses.

Parameters:
- MV_DEPTH, 32, max modelview matrices including top (>=2)
- PROJ_DEPTH, 2, max projection matrices including top (>=2)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- matrix_mode  input  1  target stack: 1 = modelview, 0 = projection
- push_en  input  1  push request, rising-edge detected
- pop_en  input  1  pop request, rising-edge detected
- load_en  input  1  load-from-BRAM request, rising-edge detected
- load_id_en  input  1  load-identity request, rising-edge detected
- load_row_in0..3  input  32 each  BRAM row words, columns 0..3
- wr_en  input  1  single-cycle multiplier writeback strobe, level-sensitive
- wr_mode  input  1  writeback target (same encoding as matrix_mode)
- wr_data  input  512  multiplier result matrix
- top_mv  output  512  modelview top; element (r,c) at bits [32*(4r+c)+:32]
- top_proj  output  512  projection top, same layout
- mv_depth  output  6  modelview matrices in use (1..MV_DEPTH)
- proj_depth  output  6  projection matrices in use (1..PROJ_DEPTH)
- busy  output  1  high while a BRAM load capture is in progress
- overflow  output  1  sticky: push attempted on a full stack
- underflow  output  1  sticky: pop attempted at depth 1

Behaviour:
- Reset (synchronous, highest priority):
  - top_mv and top_proj = identity (diagonal 32'h3F800000, others 0).
  - Depths = 1; busy, overflow and underflow = 0.
  - Edge-detect history registers = 0, so an enable already high at reset release counts as an edge.
  - A reset during a load aborts the capture; the tops stay identity.
- Edge detection: each of push_en, pop_en, load_en and load_id_en fires once per 0->1 transition. Holding an enable high does not repeat the command.
- Command mode: matrix_mode is sampled in the same cycle as the edge and applies to the whole command.
- Per-cycle priority (at most one action per cycle; lower-priority requests are dropped, no flag):
  - wr_en > load_id edge > load edge > push edge > pop edge.
  - While busy=1, all edges are dropped; wr_en is still honoured.
- wr_en: the wr_mode top is replaced by wr_data at the next edge, 1-cycle latency. Depth is unchanged.
- load_id: the selected top becomes identity next cycle. Depth is unchanged.
- load: FSM IDLE -> CAP0 -> CAP1 -> CAP2 -> CAP3 -> IDLE.
  - The load_en edge moves IDLE->CAP0 and sets busy=1.
  - In CAPi, row i of the latched target top is written from load_row_in0..3 (column j from load_row_inj).
  - BRAM data is valid one cycle after the address is issued, so row 0 is the data present in the cycle after the edge.
  - busy drops entering IDLE after CAP3; the full matrix is visible 5 cycles after the edge.
  - A wr_en to the same target during capture overrides all 16 words in that cycle; the remaining CAP rows still overwrite their rows.
- push:
  - Selected stack not full (depth < DEPTH): the top is copied to array[depth-1], depth+1, top unchanged.
  - Full: overflow set, nothing else changes.
- pop:
  - depth > 1: top <- array[depth-2], depth-1.
  - depth = 1: underflow set, nothing else changes.
- overflow and underflow stay set until rst.
- Outputs are registered. top_* always reflect stored state; there is no combinational bypass from wr_data or the load rows.

Test Plan:
- Reset, then inspect -> both tops identity (word 0 = word 5 = 32'h3F800000, word 1 = 0), depths 1, all flags 0.
- mode=1, load_en pulse, rows 0..3 = {0x3F800000+k} for k = 0..15 in row-major order -> busy high 4 cycles; top_mv word k = 0x3F800000+k at edge+5; top_proj unchanged.
- Load a matrix A into modelview, push, wr_en with wr_mode=1 and B, then pop -> after push mv_depth=2; after wr top_mv=B; after pop top_mv=A, mv_depth=1.
- Projection: push twice -> proj_depth=2 and overflow=1 after the second push; then pop twice -> proj_depth=1 and underflow=1; both flags still set 10 cycles later.
- Hold push_en high 5 cycles -> exactly one push (mv_depth 1->2); load_id edge and pop edge in the same cycle -> identity loaded, depth unchanged.
- Assert rst at CAP1 of a load -> next cycle busy=0, top_mv identity, and later row data is ignored.

Source files
------------

// File: rtl/gl_matrix_stack.sv
// Modelview/projection matrix storage with push/pop stacks and BRAM row loader.
// Both top-of-stack matrices are exposed flat, element (r,c) at word 4r+c.
module gl_matrix_stack #(
  parameter int MV_DEPTH   = 32,
  parameter int PROJ_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         matrix_mode,
  input  logic         push_en,
  input  logic         pop_en,
  input  logic         load_en,
  input  logic         load_id_en,
  input  logic [31:0]  load_row_in0,
  input  logic [31:0]  load_row_in1,
  input  logic [31:0]  load_row_in2,
  input  logic [31:0]  load_row_in3,
  input  logic         wr_en,
  input  logic         wr_mode,
  input  logic [511:0] wr_data,
  output logic [511:0] top_mv,
  output logic [511:0] top_proj,
  output logic [5:0]   mv_depth,
  output logic [5:0]   proj_depth,
  output logic         busy,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [5:0] MV_MAX = 6'(MV_DEPTH);
  localparam logic [5:0] PJ_MAX = 6'(PROJ_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAP0,
    S_CAP1,
    S_CAP2,
    S_CAP3
  } state_e;

  function automatic logic [511:0] ident();
    logic [511:0] m;
    m = '0;
    m[0*32 +: 32]  = 32'h3F80_0000;
    m[5*32 +: 32]  = 32'h3F80_0000;
    m[10*32 +: 32] = 32'h3F80_0000;
    m[15*32 +: 32] = 32'h3F80_0000;
    return m;
  endfunction

  state_e       state_q, state_d;
  logic         ld_mode_q, ld_mode_d;
  logic         push_prev_q, pop_prev_q;
  logic         load_prev_q, lid_prev_q;
  logic [511:0] mv_top_q, mv_top_d;
  logic [511:0] pj_top_q, pj_top_d;
  logic [5:0]   mv_depth_q, mv_depth_d;
  logic [5:0]   pj_depth_q, pj_depth_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic [511:0] mv_stk_q [MV_DEPTH-1];
  logic [511:0] mv_stk_d [MV_DEPTH-1];
  logic [511:0] pj_stk_q [PROJ_DEPTH-1];
  logic [511:0] pj_stk_d [PROJ_DEPTH-1];

  logic         push_edge, pop_edge;
  logic         load_edge, lid_edge;
  logic         busy_w;
  logic         cap;
  logic [1:0]   cap_row;
  logic [127:0] row_word;

  assign push_edge = push_en & ~push_prev_q;
  assign pop_edge  = pop_en & ~pop_prev_q;
  assign load_edge = load_en & ~load_prev_q;
  assign lid_edge  = load_id_en & ~lid_prev_q;
  assign busy_w    = (state_q != S_IDLE);
  assign row_word  = {load_row_in3, load_row_in2,
                      load_row_in1, load_row_in0};

  always_comb begin
    state_d    = state_q;
    ld_mode_d  = ld_mode_q;
    mv_top_d   = mv_top_q;
    pj_top_d   = pj_top_q;
    mv_depth_d = mv_depth_q;
    pj_depth_d = pj_depth_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    mv_stk_d   = mv_stk_q;
    pj_stk_d   = pj_stk_q;
    cap        = 1'b0;
    cap_row    = 2'd0;

    unique case (state_q)
      S_CAP0: begin
        cap = 1'b1; cap_row = 2'd0; state_d = S_CAP1;
      end
      S_CAP1: begin
        cap = 1'b1; cap_row = 2'd1; state_d = S_CAP2;
      end
      S_CAP2: begin
        cap = 1'b1; cap_row = 2'd2; state_d = S_CAP3;
      end
      S_CAP3: begin
        cap = 1'b1; cap_row = 2'd3; state_d = S_IDLE;
      end
      default: state_d = state_q;
    endcase

    if (cap) begin
      if (ld_mode_q) mv_top_d[{cap_row, 7'd0} +: 128] = row_word;
      else           pj_top_d[{cap_row, 7'd0} +: 128] = row_word;
    end

    // Writeback is applied last so it overrides a same-target row capture.
    if (wr_en) begin
      if (wr_mode) mv_top_d = wr_data;
      else         pj_top_d = wr_data;
    end else if (!busy_w) begin
      if (lid_edge) begin
        if (matrix_mode) mv_top_d = ident();
        else             pj_top_d = ident();
      end else if (load_edge) begin
        state_d   = S_CAP0;
        ld_mode_d = matrix_mode;
      end else if (push_edge) begin
        if (matrix_mode) begin
          if (mv_depth_q < MV_MAX) begin
            for (int i = 0; i < MV_DEPTH - 1; i++)
              if (mv_depth_q == 6'(i + 1)) mv_stk_d[i] = mv_top_q;
            mv_depth_d = mv_depth_q + 6'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          if (pj_depth_q < PJ_MAX) begin
            for (int i = 0; i < PROJ_DEPTH - 1; i++)
              if (pj_depth_q == 6'(i + 1)) pj_stk_d[i] = pj_top_q;
            pj_depth_d = pj_depth_q + 6'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end else if (pop_edge) begin
        if (matrix_mode) begin
          if (mv_depth_q > 6'd1) begin
            for (int i = 0; i < MV_DEPTH - 1; i++)
              if (mv_depth_q == 6'(i + 2)) mv_top_d = mv_stk_q[i];
            mv_depth_d = mv_depth_q - 6'd1;
          end else begin
            unf_d = 1'b1;
          end
        end else begin
          if (pj_depth_q > 6'd1) begin
            for (int i = 0; i < PROJ_DEPTH - 1; i++)
              if (pj_depth_q == 6'(i + 2)) pj_top_d = pj_stk_q[i];
            pj_depth_d = pj_depth_q - 6'd1;
          end else begin
            unf_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ld_mode_q   <= 1'b0;
      push_prev_q <= 1'b0;
      pop_prev_q  <= 1'b0;
      load_prev_q <= 1'b0;
      lid_prev_q  <= 1'b0;
      mv_top_q    <= ident();
      pj_top_q    <= ident();
      mv_depth_q  <= 6'd1;
      pj_depth_q  <= 6'd1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_mode_q   <= ld_mode_d;
      push_prev_q <= push_en;
      pop_prev_q  <= pop_en;
      load_prev_q <= load_en;
      lid_prev_q  <= load_id_en;
      mv_top_q    <= mv_top_d;
      pj_top_q    <= pj_top_d;
      mv_depth_q  <= mv_depth_d;
      pj_depth_q  <= pj_depth_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Stack bodies need no reset; only entries below the depth are ever read.
  always_ff @(posedge clk) begin
    mv_stk_q <= mv_stk_d;
    pj_stk_q <= pj_stk_d;
  end

  assign top_mv     = mv_top_q;
  assign top_proj   = pj_top_q;
  assign mv_depth   = mv_depth_q;
  assign proj_depth = pj_depth_q;
  assign busy       = busy_w;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_gl_matrix_stack.sv
// Directed bench for gl_matrix_stack: load, push/pop, writeback,
// flags, edge detection and reset during capture.
module tb_gl_matrix_stack;

  logic         clk = 1'b0;
  logic         rst;
  logic         matrix_mode;
  logic         push_en, pop_en, load_en, load_id_en;
  logic [31:0]  load_row_in0, load_row_in1;
  logic [31:0]  load_row_in2, load_row_in3;
  logic         wr_en, wr_mode;
  logic [511:0] wr_data;
  logic [511:0] top_mv, top_proj;
  logic [5:0]   mv_depth, proj_depth;
  logic         busy, overflow, underflow;

  int errors = 0;
  int checks = 0;

  logic [511:0] id_m, mat_a, mat_b, mat_c, mat_d, exp_m;

  always #5 clk = ~clk;

  gl_matrix_stack #(.MV_DEPTH(32), .PROJ_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .matrix_mode(matrix_mode),
    .push_en(push_en), .pop_en(pop_en), .load_en(load_en),
    .load_id_en(load_id_en),
    .load_row_in0(load_row_in0), .load_row_in1(load_row_in1),
    .load_row_in2(load_row_in2), .load_row_in3(load_row_in3),
    .wr_en(wr_en), .wr_mode(wr_mode), .wr_data(wr_data),
    .top_mv(top_mv), .top_proj(top_proj),
    .mv_depth(mv_depth), .proj_depth(proj_depth),
    .busy(busy), .overflow(overflow), .underflow(underflow)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_rows(input logic [511:0] m, input int r);
    load_row_in0 = m[128*r +: 32];
    load_row_in1 = m[128*r + 32 +: 32];
    load_row_in2 = m[128*r + 64 +: 32];
    load_row_in3 = m[128*r + 96 +: 32];
  endtask

  // Edge on load_en, then one row per cycle; optional writeback on wr_row.
  task automatic do_load(input logic mode, input logic [511:0] m,
                         input int wr_row, input logic [511:0] wd);
    matrix_mode = mode;
    load_en = 1'b1;
    tick(1);
    load_en = 1'b0;
    chk("busy_edge", 512'(busy), 512'(1'b1));
    for (int r = 0; r < 4; r++) begin
      set_rows(m, r);
      if (r == wr_row) begin
        wr_en = 1'b1; wr_mode = mode; wr_data = wd;
      end
      tick(1);
      wr_en = 1'b0;
      chk($sformatf("busy_row%0d", r), 512'(busy), 512'(r < 3));
    end
  endtask

  initial begin
    id_m = '0;
    id_m[0*32 +: 32]  = 32'h3F80_0000;
    id_m[5*32 +: 32]  = 32'h3F80_0000;
    id_m[10*32 +: 32] = 32'h3F80_0000;
    id_m[15*32 +: 32] = 32'h3F80_0000;
    for (int k = 0; k < 16; k++) begin
      mat_a[32*k +: 32] = 32'h3F80_0000 + 32'(k);
      mat_b[32*k +: 32] = 32'h4000_0000 + 32'(k * 3);
      mat_c[32*k +: 32] = 32'hC000_0000 + 32'(k);
      mat_d[32*k +: 32] = 32'h1234_0000 + 32'(k * 7);
    end

    rst = 1'b1; matrix_mode = 1'b0;
    push_en = 0; pop_en = 0; load_en = 0; load_id_en = 0;
    load_row_in0 = '0; load_row_in1 = '0;
    load_row_in2 = '0; load_row_in3 = '0;
    wr_en = 0; wr_mode = 0; wr_data = '0;
    tick(2);
    rst = 1'b0;

    chk("rst_mv_w0", 512'(top_mv[31:0]), 512'(32'h3F80_0000));
    chk("rst_mv_w5", 512'(top_mv[191:160]), 512'(32'h3F80_0000));
    chk("rst_mv_w1", 512'(top_mv[63:32]), 512'(0));
    chk("rst_mv", top_mv, id_m);
    chk("rst_proj", top_proj, id_m);
    chk("rst_mvd", 512'(mv_depth), 512'(1));
    chk("rst_pjd", 512'(proj_depth), 512'(1));
    chk("rst_flags", 512'({busy, overflow, underflow}), 512'(0));

    do_load(1'b1, mat_a, -1, '0);
    chk("load_mv", top_mv, mat_a);
    chk("load_proj_kept", top_proj, id_m);

    matrix_mode = 1'b1;
    push_en = 1'b1; tick(1); push_en = 1'b0;
    chk("push_mvd", 512'(mv_depth), 512'(2));
    chk("push_top_kept", top_mv, mat_a);
    wr_en = 1'b1; wr_mode = 1'b1; wr_data = mat_b;
    tick(1);
    wr_en = 1'b0;
    chk("wr_mv", top_mv, mat_b);
    chk("wr_mvd", 512'(mv_depth), 512'(2));
    pop_en = 1'b1; tick(1); pop_en = 1'b0;
    chk("pop_mv", top_mv, mat_a);
    chk("pop_mvd", 512'(mv_depth), 512'(1));

    matrix_mode = 1'b0;
    push_en = 1'b1; tick(1); push_en = 1'b0; tick(1);
    chk("pj_push1_d", 512'(proj_depth), 512'(2));
    chk("pj_push1_ovf", 512'(overflow), 512'(0));
    push_en = 1'b1; tick(1); push_en = 1'b0; tick(1);
    chk("pj_push2_d", 512'(proj_depth), 512'(2));
    chk("pj_push2_ovf", 512'(overflow), 512'(1));
    pop_en = 1'b1; tick(1); pop_en = 1'b0; tick(1);
    chk("pj_pop1_d", 512'(proj_depth), 512'(1));
    chk("pj_pop1_unf", 512'(underflow), 512'(0));
    pop_en = 1'b1; tick(1); pop_en = 1'b0; tick(1);
    chk("pj_pop2_d", 512'(proj_depth), 512'(1));
    chk("pj_pop2_unf", 512'(underflow), 512'(1));
    chk("pj_top", top_proj, id_m);
    tick(10);
    chk("sticky", 512'({overflow, underflow}), 512'(2'b11));

    matrix_mode = 1'b1;
    push_en = 1'b1; tick(5); push_en = 1'b0; tick(1);
    chk("hold_push_d", 512'(mv_depth), 512'(2));
    load_id_en = 1'b1; pop_en = 1'b1; tick(1);
    load_id_en = 1'b0; pop_en = 1'b0;
    chk("lid_pop_top", top_mv, id_m);
    chk("lid_pop_d", 512'(mv_depth), 512'(2));

    // Writeback during CAP1 replaces all words; rows 2,3 then come from C.
    do_load(1'b0, mat_c, 1, mat_d);
    exp_m = mat_d;
    exp_m[511:256] = mat_c[511:256];
    chk("cap_wr_proj", top_proj, exp_m);
    chk("cap_wr_mv_kept", top_mv, id_m);

    matrix_mode = 1'b1;
    load_en = 1'b1; tick(1); load_en = 1'b0;
    set_rows(mat_b, 0); tick(1);
    set_rows(mat_b, 1); rst = 1'b1; tick(1); rst = 1'b0;
    chk("rstcap_busy", 512'(busy), 512'(0));
    chk("rstcap_mv", top_mv, id_m);
    chk("rstcap_mvd", 512'(mv_depth), 512'(1));
    set_rows(mat_b, 2); tick(1);
    set_rows(mat_b, 3); tick(2);
    chk("rstcap_late_mv", top_mv, id_m);
    chk("rstcap_late_busy", 512'(busy), 512'(0));
    chk("rstcap_proj", top_proj, id_m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
